sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Two-master to one-port arbiter between the Ibex instruction and data interfaces and the single-ported on-chip SRAM. Performs address-window decode, round-robin arbitration, same-cycle grant, and fixed-latency response routing with error reporting for out-of-window accesses. It sits directly between `ibex_core` and `ram_64KB` in the FPGA top level.

## Interface
- `MEM_START`, 32'h0000_0000, base address of the SRAM window; must be aligned to `MEM_SIZE`.
- `MEM_SIZE`, 64*1024, window size in bytes; must be a power of two, at least 4.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `instr_req_i`  in  1  instruction fetch request.
- `instr_addr_i`  in  32  fetch byte address.
- `instr_gnt_o`  out  1  fetch accepted this cycle.
- `instr_rvalid_o`  out  1  fetch response valid.
- `instr_rdata_o`  out  32  fetch data; valid when `instr_rvalid_o`=1.
- `instr_err_o`  out  1  fetch response error; valid when `instr_rvalid_o`=1.
- `data_req_i`  in  1  load/store request.
- `data_we_i`  in  1  1 = store.
- `data_be_i`  in  4  byte enables.
- `data_addr_i`  in  32  load/store byte address.
- `data_wdata_i`  in  32  store data.
- `data_gnt_o`  out  1  load/store accepted this cycle.
- `data_rvalid_o`  out  1  load/store response valid; asserted for stores as well as loads.
- `data_rdata_o`  out  32  load data.
- `data_err_o`  out  1  load/store response error.
- `mem_req_o`  out  1  SRAM access strobe.
- `mem_we_o`  out  1  SRAM write.
- `mem_be_o`  out  4  SRAM byte enables.
- `mem_addr_o`  out  32  SRAM byte address.
- `mem_wdata_o`  out  32  SRAM write data.
- `mem_rdata_i`  in  32  SRAM read data; valid exactly one cycle after the `mem_req_o` cycle.

## Operation
- Decode: a request is in-window when `(addr & ~(MEM_SIZE-1)) == MEM_START`.
- Arbitration is combinational on the current cycle's requests.
  - If only one port is requesting, that port wins.
  - If both are requesting, the port not recorded in `last_grant` wins (round-robin).
  - `last_grant` is a 1-bit register: 0 = instr, 1 = data. It updates to the winner on every grant and resets to 1, so instr wins the first contention.
- Exactly one of `instr_gnt_o`/`data_gnt_o` is asserted in any cycle where at least one request is present. The losing port sees gnt=0 and must hold its request.
- In-window winner: drive `mem_req_o`=1 with the winner's address. Take `we`/`be`/`wdata` from the data port when data wins; when instr wins, drive `we`=0, `be`=4'hF, `wdata`=0.
- Out-of-window winner:
  - Still granted.
  - `mem_req_o`=0; no SRAM access, so stores to out-of-window addresses have no side effect.
  - Response carries err=1.
- Response pipeline: one register stage holding `rsp_valid`, `rsp_port`, and `rsp_err`, loaded every cycle from the grant decision.
  - `instr_rvalid_o = rsp_valid & ~rsp_port`; `data_rvalid_o = rsp_valid & rsp_port`.
  - `err_o` is `rsp_err` gated by the matching port's rvalid.
  - `rdata_o` = `mem_rdata_i` when the response is in-window, 32'h0 when err=1.
- No `mem_*` output changes value while `rst_i` is high.
- Out-of-window detection uses the full 32-bit address. There is no wrap-around aliasing.

## Timing
- Grant: 0-cycle, combinational in the request cycle.
- Response: exactly 1 cycle after the grant, for every grant (in-window or error). There is no other latency.
- Throughput: one grant per cycle, back-to-back. A grant in cycle N and a grant in cycle N+1 produce responses in N+1 and N+2 with no bubble.
- Outputs during and immediately after reset:
  - `instr_rvalid_o`, `data_rvalid_o`, `instr_err_o`, `data_err_o` = 0.
  - `rdata` outputs = 0.
  - `last_grant` = 1.
- Requests presented while `rst_i`=1 are not granted: `gnt`=0 and `mem_req_o`=0.
- Reset asserted in the cycle after a grant drops that response. No rvalid is produced, and the master must be reset along with the arbiter.
- Simultaneous requests on every cycle strictly alternate winners: instr, data, instr, ...
- Single-requester streams never wait; `last_grant` does not block them.

## Test plan
- Reset, then fetch 0x0000_0080 with instr only -> `instr_gnt_o`=1 in the same cycle, `mem_req_o`=1 with `mem_addr_o`=0x80; next cycle `instr_rvalid_o`=1, `instr_rdata_o`=SRAM word, `instr_err_o`=0.
- Both request continuously for 6 cycles (instr 0x100, data load 0x2000) -> grants alternate I,D,I,D,I,D starting with instr; each rvalid appears on the matching port one cycle later with no cross-routing.
- Data store to 0x0000_0010 (`be`=4'b0011, `wdata`=0xDEADBEEF) -> `mem_we_o`=1, `mem_be_o`=0011; next cycle `data_rvalid_o`=1, `data_err_o`=0; a subsequent read of 0x10 returns 0x????BEEF.
- Data store to 0x0001_0000 (just past the 64 kB window) -> `data_gnt_o`=1, `mem_req_o`=0; next cycle `data_rvalid_o`=1, `data_err_o`=1, `data_rdata_o`=0; SRAM contents unchanged.
- Back-to-back fetches at 0x0, 0x4, 0x8 -> three consecutive grants and three consecutive rvalids, each one cycle after its grant.
- Grant a load, then assert `rst_i` in the next cycle -> `data_rvalid_o`=0 throughout reset; after release, the first contention is won by instr.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Two-master (Ibex instr/data) to single-port SRAM arbiter: window decode,
// round-robin grant in the request cycle, one-stage fixed-latency response routing.
module sram_bus_arbiter #(
  parameter logic [31:0] MEM_START = 32'h0000_0000,
  parameter int unsigned MEM_SIZE  = 64 * 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] WIN_MASK = ~32'(MEM_SIZE - 1);

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  logic     last_grant_q, last_grant_d;
  logic     rsp_valid_q, rsp_valid_d;
  logic     rsp_port_q, rsp_port_d;
  logic     rsp_err_q, rsp_err_d;

  logic     instr_win, data_win, gnt_any, in_win;
  logic     rsp_live;
  mem_cmd_t cmd;

  // Instr wins when alone, or on contention when data won last time.
  always_comb begin
    instr_win = instr_req_i & ~rst_i & (~data_req_i | last_grant_q);
    data_win  = data_req_i & ~rst_i & ~instr_win;
    gnt_any   = instr_win | data_win;

    cmd = '0;
    if (data_win) begin
      cmd.we    = data_we_i;
      cmd.be    = data_be_i;
      cmd.addr  = data_addr_i;
      cmd.wdata = data_wdata_i;
    end else begin
      cmd.be    = 4'hF;
      cmd.addr  = instr_addr_i;
    end
    in_win = (cmd.addr & WIN_MASK) == MEM_START;

    last_grant_d = gnt_any ? data_win : last_grant_q;
    rsp_valid_d  = gnt_any;
    rsp_port_d   = data_win;
    rsp_err_d    = gnt_any & ~in_win;
  end

  // mem_* are held at zero unless an in-window grant is issued, so they stay
  // quiet through reset and idle cycles.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (gnt_any && in_win) begin
      mem_req_o   = 1'b1;
      mem_we_o    = cmd.we;
      mem_be_o    = cmd.be;
      mem_addr_o  = cmd.addr;
      mem_wdata_o = cmd.wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;

  // Reset in the response cycle drops the pending response immediately.
  assign rsp_live       = rsp_valid_q & ~rst_i;
  assign instr_rvalid_o = rsp_live & ~rsp_port_q;
  assign data_rvalid_o  = rsp_live & rsp_port_q;
  assign instr_err_o    = instr_rvalid_o & rsp_err_q;
  assign data_err_o     = data_rvalid_o & rsp_err_q;
  assign instr_rdata_o  = (instr_rvalid_o && !rsp_err_q) ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_o && !rsp_err_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: vector table plus reset corner sequence, with a
// response scoreboard and an SRAM shadow for expected read data.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] instr_rdata, data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_bus_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Behavioural 64 kB SRAM: read data one cycle after the strobe.
  logic [31:0] sram [16384];
  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = init_word(i);
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_req) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) sram[mem_addr[15:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata <= sram[mem_addr[15:2]];
        end
      end
    end
  end

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] da;
    logic [31:0] wd;
    bit          egi;
    bit          egd;
    bit          emr;
  } vec_t;

  localparam logic [31:0] WMASK = 32'hFFFF_0000;

  int          checks = 0;
  int          errors = 0;
  rsp_t        exp_q[$];
  logic [31:0] shadow [16384];
  bit          m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check the previous grant's response, check this
  // cycle's grant and SRAM command against the model, then advance the clock.
  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit we, input logic [3:0] be,
                      input logic [31:0] da, input logic [31:0] wd,
                      output bit gi, output bit gd, output bit mr);
    rsp_t        e;
    bit          egi, egd, inwin, emr;
    logic [31:0] a;
    int          idx;
    rst = r; instr_req = ir; instr_addr = ia;
    data_req = dr; data_we = we; data_be = be; data_addr = da; data_wdata = wd;
    #3;
    if (r) begin
      exp_q.delete();
      chk("rst_instr_rvalid", instr_rvalid, 0);
      chk("rst_data_rvalid", data_rvalid, 0);
      chk("rst_errs", {instr_err, data_err}, 0);
      chk("rst_rdata", instr_rdata | data_rdata, 0);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("instr_rvalid", instr_rvalid, !e.port);
      chk("data_rvalid", data_rvalid, e.port);
      chk("rsp_err", e.port ? data_err : instr_err, e.err);
      chk("other_err", e.port ? instr_err : data_err, 0);
      if (e.chk_data) chk("rsp_rdata", e.port ? data_rdata : instr_rdata, e.data);
    end else begin
      chk("idle_rvalid", {instr_rvalid, data_rvalid}, 0);
    end

    egi   = !r && ir && (!dr || m_last);
    egd   = !r && dr && !egi;
    a     = egd ? da : ia;
    inwin = (a & WMASK) == 32'h0;
    emr   = (egi || egd) && inwin;
    chk("instr_gnt", instr_gnt, egi);
    chk("data_gnt", data_gnt, egd);
    chk("mem_req", mem_req, emr);
    if (emr) begin
      chk("mem_addr", mem_addr, a);
      chk("mem_we", mem_we, egd && we);
      chk("mem_be", mem_be, egd ? be : 4'hF);
      chk("mem_wdata", mem_wdata, (egd && we) ? wd : 32'h0);
    end
    if (r) chk("rst_mem_quiet", {mem_we, mem_be, mem_addr, mem_wdata} != 0, 0);

    if (egi || egd) begin
      idx = int'(a[15:2]);
      e.port = egd;
      e.err = !inwin;
      e.chk_data = !inwin || !(egd && we);
      e.data = inwin ? shadow[idx] : 32'h0;
      exp_q.push_back(e);
      if (inwin && egd && we)
        for (int b = 0; b < 4; b++) if (be[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
      m_last = egd;
    end
    if (r) m_last = 1'b1;
    gi = instr_gnt; gd = data_gnt; mr = mem_req;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  bit   gi, gd, mr;

  initial begin
    for (int i = 0; i < 16384; i++) shadow[i] = init_word(i);
    m_last = 1'b1;

    // Reset with requests present: nothing granted.
    step(1, 1, 32'h80, 1, 1, 4'hF, 32'h40, 32'h1234_5678, gi, gd, mr);
    step(1, 1, 32'h84, 1, 0, 4'hF, 32'h44, 32'h0, gi, gd, mr);

    tbl.push_back('{1, 32'h0000_0080, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1});
    tbl.push_back('{0, 32'h0,         1, 0, 4'hF, 32'h0000_2000, 32'h0,         0, 1, 1});
    for (int k = 0; k < 6; k++)
      tbl.push_back('{1, 32'h0000_0100, 1, 0, 4'hF, 32'h0000_2000, 32'h0, (k % 2) == 0, (k % 2) == 1, 1});
    tbl.push_back('{0, 32'h0,         1, 1, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 1});
    tbl.push_back('{0, 32'h0,         1, 0, 4'hF, 32'h0000_0010, 32'h0,         0, 1, 1});
    tbl.push_back('{0, 32'h0,         1, 1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D, 0, 1, 0});
    tbl.push_back('{0, 32'h0,         1, 0, 4'hF, 32'h0000_0010, 32'h0,         0, 1, 1});
    tbl.push_back('{1, 32'h0000_0000, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1});
    tbl.push_back('{1, 32'h0000_0004, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1});
    tbl.push_back('{1, 32'h0000_0008, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1});
    tbl.push_back('{1, 32'hFFFF_FFFC, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 0});
    tbl.push_back('{0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 0});

    foreach (tbl[i]) begin
      step(0, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].we, tbl[i].be, tbl[i].da, tbl[i].wd,
           gi, gd, mr);
      chk($sformatf("vec%0d_gnt", i), {gi, gd, mr}, {tbl[i].egi, tbl[i].egd, tbl[i].emr});
    end

    chk("sram_store_merge", sram[4], {init_word(4)[31:16], 16'hBEEF});
    chk("sram_oow_untouched", sram[0], init_word(0));

    // Load granted, then reset in the response cycle: response dropped.
    step(0, 0, 32'h0, 1, 0, 4'hF, 32'h0000_0200, 32'h0, gi, gd, mr);
    chk("pre_rst_load_gnt", gd, 1);
    step(1, 1, 32'h100, 1, 0, 4'hF, 32'h0000_0200, 32'h0, gi, gd, mr);
    step(1, 1, 32'h100, 1, 0, 4'hF, 32'h0000_0200, 32'h0, gi, gd, mr);
    step(0, 1, 32'h100, 1, 0, 4'hF, 32'h0000_0204, 32'h0, gi, gd, mr);
    chk("post_rst_first_contention", {gi, gd}, 2'b10);
    step(0, 1, 32'h104, 1, 0, 4'hF, 32'h0000_0204, 32'h0, gi, gd, mr);
    chk("post_rst_second_contention", {gi, gd}, 2'b01);
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, gi, gd, mr);
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, gi, gd, mr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
